// File: rtl/opb_register_simulink2ppc_snap_pkg.sv
// Shared register map and field positions for the Simulink-to-PPC snapshot register.
package opb_register_simulink2ppc_snap_pkg;

    typedef logic [1:0] word_idx_t;

    // Word indices inside the 4-word slave window
    localparam word_idx_t REG_DATA   = 2'd0;
    localparam word_idx_t REG_STATUS = 2'd1;
    localparam word_idx_t REG_CTRL   = 2'd2;

    // STATUS fields
    localparam int STAT_NEW_BIT = 0;
    localparam int STAT_OVF_BIT = 1;
    localparam int STAT_CNT_LSB = 16;

    // CTRL fields
    localparam int CTRL_FREEZE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    localparam logic [15:0] OVF_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/opb_register_simulink2ppc_snap_opb_slave_ack.sv
// OPB slave address decode with a single-cycle transfer acknowledge.
// A hit is blocked while the ack is high, so a held select acks every other cycle.
module opb_slave_ack
    import opb_register_simulink2ppc_snap_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01000200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010002FF,
    parameter int          C_OPB_AWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:C_OPB_AWIDTH-1] abus,
    input  logic                  select,
    input  logic                  rnw,
    output logic                  xfer_ack,
    output logic                  rd_strobe,
    output logic                  wr_strobe,
    output word_idx_t             word_idx
);

    logic hit;
    logic ack_p1;

    assign hit       = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR) && !ack_p1;
    assign rd_strobe = hit && rnw;
    assign wr_strobe = hit && !rnw;
    assign word_idx  = abus[C_OPB_AWIDTH-4:C_OPB_AWIDTH-3];
    assign xfer_ack  = ack_p1;

    // Acknowledge exactly one cycle after a hit; reset drops a pending access
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_p1 <= 1'b0;
        end else begin
            ack_p1 <= hit;
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Fabric-to-PPC return register: captures a fabric word and exposes it,
// a new/overflow status and freeze/clear control through a 4-word OPB window.
module opb_register_simulink2ppc_snap
    import opb_register_simulink2ppc_snap_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01000200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010002FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_new
);

    localparam bit FAMILY_IS_V5 = (C_FAMILY == "virtex5");

    logic        rd_strobe;
    logic        wr_strobe;
    word_idx_t   word_idx;

    logic [31:0] wdata;
    logic [31:0] data_q;
    logic        new_q;
    logic        ovf_q;
    logic [15:0] ovf_cnt_q;
    logic        freeze_q;
    logic [31:0] rdata_p1;
    logic [31:0] rd_mux;

    logic        data_rd;
    logic        ctrl_wr;
    logic        clear_req;
    logic        capture;
    logic        ovf_event;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == OVF_CNT_MAX) ? v : v + 16'd1;
    endfunction

    opb_slave_ack #(
        .C_BASEADDR  (C_BASEADDR),
        .C_HIGHADDR  (C_HIGHADDR),
        .C_OPB_AWIDTH(C_OPB_AWIDTH)
    ) u_ack (
        .clk      (OPB_Clk),
        .rst      (OPB_Rst),
        .abus     (OPB_ABus),
        .select   (OPB_select),
        .rnw      (OPB_RNW),
        .xfer_ack (Sl_xferAck),
        .rd_strobe(rd_strobe),
        .wr_strobe(wr_strobe),
        .word_idx (word_idx)
    );

    // OPB bit 0 is the MSB, so a straight vector copy maps DBus[31] to register bit 0
    assign wdata = 32'(OPB_DBus);

    assign data_rd   = rd_strobe && (word_idx == REG_DATA);
    assign ctrl_wr   = wr_strobe && (word_idx == REG_CTRL);
    assign clear_req = ctrl_wr && wdata[CTRL_CLEAR_BIT];
    assign capture   = user_valid && !freeze_q;
    // A strobe onto unread data overflows, unless a DATA read consumes it this cycle
    // or a clear wins over the count
    assign ovf_event = user_valid && new_q && !data_rd && !clear_req;

    // Register read multiplexer, sampled in the hit cycle
    always_comb begin
        rd_mux = '0;
        case (word_idx)
            REG_DATA: rd_mux = data_q;
            REG_STATUS: begin
                rd_mux[STAT_NEW_BIT]                = new_q;
                rd_mux[STAT_OVF_BIT]                = ovf_q;
                rd_mux[STAT_CNT_LSB +: 16]          = ovf_cnt_q;
            end
            REG_CTRL: rd_mux[CTRL_FREEZE_BIT] = freeze_q;
            default: rd_mux = '0;
        endcase
    end

    // Capture, status and control state plus the registered read bus
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_q    <= '0;
            new_q     <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
            freeze_q  <= 1'b0;
            rdata_p1  <= '0;
        end else begin
            rdata_p1 <= rd_strobe ? rd_mux : 32'd0;

            if (capture) begin
                data_q <= user_data_in;
            end

            if (capture) begin
                new_q <= 1'b1;
            end else if (data_rd || clear_req) begin
                new_q <= 1'b0;
            end

            if (clear_req) begin
                ovf_q     <= 1'b0;
                ovf_cnt_q <= '0;
            end else if (ovf_event) begin
                ovf_q     <= 1'b1;
                ovf_cnt_q <= sat_inc(ovf_cnt_q);
            end

            if (ctrl_wr) begin
                freeze_q <= wdata[CTRL_FREEZE_BIT];
            end
        end
    end

    assign Sl_DBus    = C_OPB_DWIDTH'(rdata_p1);
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign user_new   = new_q;

    logic unused_ok;
    assign unused_ok = ^{OPB_BE, OPB_seqAddr, wdata[31:2], FAMILY_IS_V5};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Scoreboard bench: stimulus pushes expected OPB responses, a negedge monitor pops on each ack.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h01000200;
    localparam logic [31:0] HIGH = 32'h010002FF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:31] abus = '0;
    logic [0:3]  be = '0;
    logic [0:31] dbus = '0;
    logic        rnw = 1'b0;
    logic        sel = 1'b0;
    logic        seq = 1'b0;
    logic [0:31] sl_dbus;
    logic        sl_err, sl_retry, sl_tout, sl_ack;
    logic [31:0] user_data = '0;
    logic        user_valid = 1'b0;
    logic        user_new;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk     (clk),
        .OPB_Rst     (rst),
        .OPB_ABus    (abus),
        .OPB_BE      (be),
        .OPB_DBus    (dbus),
        .OPB_RNW     (rnw),
        .OPB_select  (sel),
        .OPB_seqAddr (seq),
        .Sl_DBus     (sl_dbus),
        .Sl_errAck   (sl_err),
        .Sl_retry    (sl_retry),
        .Sl_toutSup  (sl_tout),
        .Sl_xferAck  (sl_ack),
        .user_data_in(user_data),
        .user_valid  (user_valid),
        .user_new    (user_new)
    );

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
    } sb_t;

    sb_t sbq[$];

    int n_err = 0;
    int n_chk = 0;

    // Reference model state (what the register set holds, in plain terms)
    logic [31:0] m_data = '0;
    logic        m_new = 1'b0;
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;
    logic        m_freeze = 1'b0;
    logic        m_ack = 1'b0;
    logic        mon_en = 1'b0;
    logic        prev_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
        end
    endtask

    // One clock of stimulus; the model decides what the slave must answer
    task automatic step(input logic r, input logic s, input logic [31:0] a, input logic rw,
                        input logic [31:0] wd, input logic uv, input logic [31:0] ud,
                        input logic use_exp, input logic [31:0] exp_v);
        logic        hit, drd, cwr, clr, cap, oev;
        logic [1:0]  idx;
        logic [31:0] mv;
        sb_t         e;
        rst = r; sel = s; abus = a; rnw = rw; dbus = wd;
        user_valid = uv; user_data = ud;
        be = 4'($urandom); seq = 1'($urandom);
        hit = s && (a >= BASE) && (a <= HIGH) && !m_ack;
        idx = a[3:2];
        case (idx)
            2'd0: mv = m_data;
            2'd1: mv = 32'((m_cnt << 16) + (m_ovf ? 2 : 0) + (m_new ? 1 : 0));
            2'd2: mv = m_freeze ? 32'd1 : 32'd0;
            default: mv = 32'd0;
        endcase
        if (hit && !r) begin
            e.is_rd = rw;
            e.data  = use_exp ? exp_v : mv;
            sbq.push_back(e);
        end
        drd = hit && rw && idx == 2'd0;
        cwr = hit && !rw && idx == 2'd2;
        clr = cwr && wd[1];
        cap = uv && !m_freeze;
        oev = uv && m_new && !drd && !clr;
        @(posedge clk);
        #1;
        if (r) begin
            m_data = '0; m_new = 0; m_ovf = 0; m_cnt = 0; m_freeze = 0; m_ack = 0;
        end else begin
            if (cap) m_data = ud;
            if (cap) m_new = 1'b1;
            else if (drd || clr) m_new = 1'b0;
            if (clr) begin
                m_ovf = 1'b0; m_cnt = 0;
            end else if (oev) begin
                m_ovf = 1'b1;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            if (cwr) m_freeze = wd[0];
            m_ack = hit;
        end
    endtask

    task automatic idle();
        step(0, 0, 32'd0, 1, 32'd0, 0, 32'd0, 0, 32'd0);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp_v);
        step(0, 1, BASE + off, 1, 32'd0, 0, 32'd0, 1, exp_v);
        idle();
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        step(0, 1, BASE + off, 0, d, 0, 32'd0, 0, 32'd0);
        idle();
    endtask

    task automatic cap(input logic [31:0] d);
        step(0, 0, 32'd0, 1, 32'd0, 1, d, 0, 32'd0);
    endtask

    // Monitor: compare every ack against the scoreboard and the idle bus against zero
    always @(negedge clk) begin
        sb_t e;
        if (mon_en) begin
            chk("ack_vs_model", 32'(sl_ack), 32'(m_ack));
            chk("user_new", 32'(user_new), 32'(m_new));
            if (sl_ack) begin
                chk("ack_not_back_to_back", 32'(prev_ack), 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    if (e.is_rd) chk("read_data", 32'(sl_dbus), e.data);
                end
            end else begin
                chk("dbus_idle_zero", 32'(sl_dbus), 32'd0);
            end
            prev_ack = sl_ack;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic        s, rw, uv, r;
        logic [31:0] a, wd;

        step(1, 0, 32'd0, 1, 32'd0, 0, 32'd0, 0, 32'd0);
        step(1, 0, 32'd0, 1, 32'd0, 0, 32'd0, 0, 32'd0);
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_ack", 32'(sl_ack), 32'd0);
        chk("reset_user_new", 32'(user_new), 32'd0);

        // Registers read zero after reset
        rd(32'h0, 32'h0);
        rd(32'h4, 32'h0);
        rd(32'h8, 32'h0);

        // Single capture, then DATA read clears new
        cap(32'hDEADBEEF);
        rd(32'h4, 32'h00000001);
        rd(32'h0, 32'hDEADBEEF);
        rd(32'h4, 32'h00000000);

        // Three captures overflow twice; clear coinciding with capture of 3
        cap(32'd1); cap(32'd2); cap(32'd3);
        rd(32'h0 + 32'h4, 32'h00020003);
        step(0, 1, BASE + 32'h8, 0, 32'h2, 1, 32'd3, 0, 32'd0);
        idle();
        rd(32'h4, 32'h00000001);
        rd(32'h0, 32'h00000003);

        // Freeze blocks the load; a frozen strobe onto new data still overflows
        wr(32'h8, 32'h1);
        cap(32'h55);
        rd(32'h8, 32'h00000001);
        rd(32'h4, 32'h00000000);
        rd(32'h0, 32'h00000003);
        wr(32'h8, 32'h0);
        cap(32'h55);
        wr(32'h8, 32'h1);
        cap(32'h66);
        rd(32'h4, 32'h00010003);
        rd(32'h0, 32'h00000055);
        wr(32'h8, 32'h2);
        rd(32'h8, 32'h00000000);
        rd(32'h4, 32'h00000000);
        wr(32'hC, 32'hFFFFFFFF);
        rd(32'hC, 32'h00000000);
        wr(32'h0, 32'h12345678);
        rd(32'h0, 32'h00000055);

        // Capture in the same cycle as a DATA read hit
        step(0, 1, BASE, 1, 32'd0, 1, 32'h77, 1, 32'h00000055);
        idle();
        rd(32'h4, 32'h00000001);
        rd(32'h0, 32'h00000077);

        // Select held four cycles: acks in cycles 2 and 4 only
        step(0, 1, BASE + 32'h4, 1, 32'd0, 0, 32'd0, 1, 32'h0);
        step(0, 1, BASE + 32'h4, 1, 32'd0, 0, 32'd0, 1, 32'h0);
        step(0, 1, BASE + 32'h4, 1, 32'd0, 0, 32'd0, 1, 32'h0);
        step(0, 1, BASE + 32'h4, 1, 32'd0, 0, 32'd0, 1, 32'h0);
        idle();

        // Reset in the hit cycle, and accesses outside the window, are never acked
        cap(32'hA5A5A5A5);
        step(1, 1, BASE, 1, 32'd0, 0, 32'd0, 0, 32'd0);
        @(negedge clk);
        chk("no_ack_after_rst_hit", 32'(sl_ack), 32'd0);
        step(0, 1, 32'h01000300, 1, 32'd0, 0, 32'd0, 0, 32'd0);
        @(negedge clk);
        chk("no_ack_above_window", 32'(sl_ack), 32'd0);
        step(0, 1, 32'h010001FC, 0, 32'h2, 0, 32'd0, 0, 32'd0);
        @(negedge clk);
        chk("no_ack_below_window", 32'(sl_ack), 32'd0);
        idle();
        rd(32'h0, 32'h00000000);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            s  = ($urandom_range(0, 2) != 0);
            a  = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, 63) * 4);
            rw = 1'($urandom_range(0, 1));
            wd = $urandom;
            if ($urandom_range(0, 7) != 0) wd[1] = 1'b0;
            if ($urandom_range(0, 2) != 0) wd[0] = 1'b0;
            uv = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 199) == 0);
            step(r, s, a, rw, wd, uv, $urandom, 0, 32'd0);
        end
        idle();
        idle();
        @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc_snap.md
Name: opb_register_simulink2ppc_snap

Overview:
Return path of the PPC/Simulink register pair: fabric logic pushes 32-bit words in, and the PowerPC reads them over OPB. It is an OPB slave with a 4-word window holding a capture register, status (new-data flag, overflow count) and control (freeze, clear). It runs in a single clock domain alongside the OPB-side register cores in the XPS_ROACH_base design.

Parameters:
C_BASEADDR, 32'h01000200, first byte address of the slave window.
C_HIGHADDR, 32'h010002FF, last byte address of the slave window.
C_OPB_AWIDTH, 32, OPB address width.
C_OPB_DWIDTH, 32, OPB data width.
C_FAMILY, "virtex5", target family (informational).

Ports:
OPB_Clk  in  1  sole clock for OPB and user side.
OPB_Rst  in  1  synchronous, active-high reset.
OPB_ABus  in  [0:31]  address, bit 0 = MSB.
OPB_BE  in  [0:3]  byte enables (ignored; full-word access only).
OPB_DBus  in  [0:31]  write data.
OPB_RNW  in  1  1 = read, 0 = write.
OPB_select  in  1  master transfer request.
OPB_seqAddr  in  1  ignored.
Sl_DBus  out  [0:31]  read data; zero unless Sl_xferAck is high.
Sl_errAck  out  1  tied 0.
Sl_retry  out  1  tied 0.
Sl_toutSup  out  1  tied 0.
Sl_xferAck  out  1  one-cycle transfer acknowledge.
user_data_in  in  [31:0]  fabric word to capture.
user_valid  in  1  capture strobe for user_data_in.
user_new  out  1  copy of STATUS.new, for fabric back-pressure.

Behaviour:
- Reset (OPB_Rst=1 at a clock edge): DATA=0, new=0, ovf=0, ovf_cnt=0, freeze=0, Sl_xferAck=0, Sl_DBus=0, user_new=0. Reset during a pending access drops it; no ack is issued.
- Hit = OPB_select & C_BASEADDR<=OPB_ABus<=C_HIGHADDR & !Sl_xferAck. Word index = OPB_ABus[28:29].
- Latency: hit at edge t gives Sl_xferAck=1 for exactly the cycle after t, then 0. Read data is the register value sampled at t. Select held high after ack does not produce a second ack in the following cycle.
- Sl_DBus[0:31] = reg[31:0], so Sl_DBus[31] carries register bit 0.
- Register map:
  - 0x0 DATA (read-only): captured word. A read clears new.
  - 0x4 STATUS (read-only): [0] new, [1] ovf (sticky), [15:2]=0, [31:16] ovf_cnt.
  - 0x8 CTRL (read/write): [0] freeze. [1] clear, write-1, self-clearing, reads 0. Clear zeroes new, ovf and ovf_cnt; DATA is kept.
  - 0xC: reads 0; writes ignored.
  - Writes to DATA or STATUS are acked with no effect.
- Capture: user_valid & !freeze loads DATA and sets new. If new was already 1 and no DATA read is clearing it in the same cycle, set ovf and increment ovf_cnt, saturating at 0xFFFF.
- Capture while frozen: DATA is unchanged, but the strobe still counts as an overflow if new=1.
- Simultaneous capture and DATA read in the same cycle: the read returns the old DATA, new ends at 1, and no overflow is counted.
- Simultaneous capture and CTRL clear: clear takes priority for ovf and ovf_cnt; new ends at 1 and DATA is loaded.
- user_new = registered new (same cycle as STATUS[0]).

Decomposition:
- Shared package: register offsets (DATA=0, STATUS=1, CTRL=2 as word indices), STATUS and CTRL bit positions, OVF_CNT_MAX=16'hFFFF.
- One sub-module is natural: opb_slave_ack. It does address decode and the single-cycle ack/guard, and emits rd_strobe, wr_strobe and word index. It is reused by the write-direction register core.

Test Plan:
- Reset, then read 0x0, 0x4, 0x8 -> each read acked 1 cycle after select with Sl_DBus=0.
- user_valid with 0xDEADBEEF, then read STATUS -> 0x00000001; read DATA -> 0xDEADBEEF; read STATUS again -> 0x00000000.
- Three captures (1, 2, 3) with no read -> DATA=3, STATUS=0x00020003; write CTRL=0x2 -> STATUS=0x00000001, DATA still 3.
- Write CTRL=0x1, capture 0x55 -> DATA holds its prior value, and the strobe counts as an overflow if new=1. Write CTRL=0 then capture 0x55 -> DATA=0x55. Read CTRL while frozen -> 0x00000001.
- user_valid in the same cycle as a DATA-read hit -> read returns old value, STATUS reads 0x00000001 (new=1, no ovf).
- Hold OPB_select high for 4 cycles -> Sl_xferAck pulses only in cycles 2 and 4, never on consecutive cycles. Assert OPB_Rst in the hit cycle -> no ack. An address outside the window -> no ack.
